// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among NPORTS cache-style clients, one transaction in flight.
// Default is round-robin grant; define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req_en,
  input  logic [NPORTS-1:0]    req_wr,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*DW-1:0] req_wdata,
  output logic [DW-1:0]        req_rdata,
  output logic [NPORTS-1:0]    req_rdy,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_en,
  output logic                 mem_wr,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_rdy,
  output logic                 busy,
  output logic [2:0]           grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] LAST_PORT = 3'(NPORTS - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        last_grant_q, last_grant_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]     req_rdata_q, req_rdata_d;
  logic [NPORTS-1:0] req_rdy_q, req_rdy_d;

  logic              win_valid;
  logic [2:0]        win_idx;
  logic              win_wr;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last (winning) assignment.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req_en[i]) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end
`else
  logic [2:0]          rr_start;
  logic [2*NPORTS-1:0] req_dbl;

  // Rotate requests so bit 0 is the port after last_grant; the lowest set bit wins.
  always_comb begin
    rr_start  = (last_grant_q >= LAST_PORT) ? 3'd0 : last_grant_q + 3'd1;
    req_dbl   = {req_en, req_en} >> rr_start;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int j = NPORTS - 1; j >= 0; j--) begin
      if (req_dbl[j]) begin
        win_valid = 1'b1;
        win_idx   = (int'(rr_start) + j >= NPORTS) ? 3'(int'(rr_start) + j - NPORTS)
                                                   : 3'(int'(rr_start) + j);
      end
    end
  end
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (win_idx == 3'(i)) begin
        win_wr    = req_wr[i];
        win_addr  = req_addr[i*AW +: AW];
        win_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_en_d     = mem_en_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    req_rdata_d  = req_rdata_q;
    busy_d       = busy_q;
    req_rdy_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d      = ST_BUSY;
          grant_d      = win_idx;
          last_grant_d = win_idx;
          mem_en_d     = 1'b1;
          mem_wr_d     = win_wr;
          mem_addr_d   = win_addr;
          mem_wdata_d  = win_wdata;
          busy_d       = 1'b1;
        end
      end
      ST_BUSY: begin
        // Completes even if the client dropped en meanwhile; the access is already committed.
        if (mem_rdy) begin
          state_d     = ST_RESP;
          req_rdata_d = mem_rdata;
          mem_en_d    = 1'b0;
          mem_wr_d    = 1'b0;
          req_rdy_d   = NPORTS'(1) << grant_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_PORT;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      req_rdata_q  <= '0;
      req_rdy_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      req_rdata_q  <= req_rdata_d;
      req_rdy_q    <= req_rdy_d;
      busy_q       <= busy_d;
    end
  end

  assign req_rdata = req_rdata_q;
  assign req_rdy   = req_rdy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-port instance for the main scenarios and a 4-port
// instance for wrap-around round-robin order. Inputs change and outputs are checked on negedge.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // 2-port instance
  logic [1:0]  req_en, req_wr, req_rdy;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_rdy, busy;
  logic [2:0]  grant;

  // 4-port instance
  logic [3:0]   q_req_en, q_req_wr, q_req_rdy;
  logic [127:0] q_req_addr, q_req_wdata;
  logic [31:0]  q_req_rdata, q_mem_addr, q_mem_wdata, q_mem_rdata;
  logic         q_mem_en, q_mem_wr, q_mem_rdy, q_busy;
  logic [2:0]   q_grant;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.NPORTS(2), .AW(32), .DW(32)) dut2 (
    .clock(clock), .reset(reset),
    .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_rdy(req_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .busy(busy), .grant(grant)
  );

  mem_arbiter #(.NPORTS(4), .AW(32), .DW(32)) dut4 (
    .clock(clock), .reset(reset),
    .req_en(q_req_en), .req_wr(q_req_wr), .req_addr(q_req_addr), .req_wdata(q_req_wdata),
    .req_rdata(q_req_rdata), .req_rdy(q_req_rdy),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_en(q_mem_en), .mem_wr(q_mem_wr),
    .mem_rdata(q_mem_rdata), .mem_rdy(q_mem_rdy), .busy(q_busy), .grant(q_grant)
  );

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_en = '0; req_wr = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_rdy = 1'b0;
    q_req_en = '0; q_req_wr = '0; q_req_addr = '0; q_req_wdata = '0; q_mem_rdata = '0; q_mem_rdy = 1'b0;
    step();
    step();
    checks++;
    if ({mem_en, mem_wr, busy, req_rdy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: en/wr/busy/rdy=%b want 00000", {mem_en, mem_wr, busy, req_rdy});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || req_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, req_rdata);
    end
    checks++;
    if (grant !== 3'd0) begin
      errors++; $display("FAIL reset_grant: got %0d want 0", grant);
    end
    checks++;
    if ({q_mem_en, q_mem_wr, q_busy, q_req_rdy, q_grant} !== 10'b0) begin
      errors++; $display("FAIL reset_dut4: got %b want 0", {q_mem_en, q_mem_wr, q_busy, q_req_rdy, q_grant});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    req_en = 2'b01; req_wr = 2'b00; req_addr[31:0] = 32'h100;
    step();
    checks++;
    if ({mem_en, mem_wr, busy, req_rdy} !== 5'b10100 || mem_addr !== 32'h100 || grant !== 3'd0) begin
      errors++; $display("FAIL read_issue: en/wr/busy/rdy=%b addr=%h grant=%0d want 10100 100 0",
                         {mem_en, mem_wr, busy, req_rdy}, mem_addr, grant);
    end
    mem_rdy = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    checks++;
    if (req_rdy !== 2'b01 || req_rdata !== 32'hDEADBEEF || mem_en !== 1'b0) begin
      errors++; $display("FAIL read_resp: rdy=%b rdata=%h mem_en=%b want 01 deadbeef 0", req_rdy, req_rdata, mem_en);
    end
    mem_rdy = 1'b0; req_en = 2'b00;
    step();
    checks++;
    if (req_rdy !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL read_idle: rdy=%b busy=%b want 00 0", req_rdy, busy);
    end
  endtask

  task automatic test_write();
    req_en = 2'b10; req_wr = 2'b10; req_addr[63:32] = 32'h200; req_wdata[63:32] = 32'h12345678;
    step();
    checks++;
    if ({mem_en, mem_wr} !== 2'b11 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678 || grant !== 3'd1) begin
      errors++; $display("FAIL write_issue: en/wr=%b addr=%h wdata=%h grant=%0d want 11 200 12345678 1",
                         {mem_en, mem_wr}, mem_addr, mem_wdata, grant);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({mem_en, mem_wr} !== 2'b11 || mem_wdata !== 32'h12345678 || req_rdy !== 2'b00) begin
        errors++; $display("FAIL write_hold%0d: en/wr=%b wdata=%h rdy=%b want 11 12345678 00",
                           k, {mem_en, mem_wr}, mem_wdata, req_rdy);
      end
    end
    mem_rdy = 1'b1; mem_rdata = 32'hAAAA5555;
    step();
    checks++;
    if (req_rdy !== 2'b10 || {mem_en, mem_wr} !== 2'b00) begin
      errors++; $display("FAIL write_resp: rdy=%b en/wr=%b want 10 00", req_rdy, {mem_en, mem_wr});
    end
    mem_rdy = 1'b0; req_en = 2'b00; req_wr = 2'b00;
    step();
  endtask

  task automatic test_wait_states();
    int pulses;
    req_en = 2'b01; req_addr[31:0] = 32'h300;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h300 || req_rdy !== 2'b00) begin
        errors++; $display("FAIL wait_hold%0d: en=%b addr=%h rdy=%b want 1 300 00", k, mem_en, mem_addr, req_rdy);
      end
      step();
    end
    mem_rdy = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    checks++;
    if (req_rdy !== 2'b01 || req_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL wait_resp: rdy=%b rdata=%h want 01 0badf00d", req_rdy, req_rdata);
    end
    mem_rdy = 1'b0; req_en = 2'b00;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (req_rdy !== 2'b00) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL wait_extra_rdy: got %0d extra pulses want 0", pulses);
    end
    // mem_rdy while idle must not start or complete anything
    mem_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({mem_en, busy, req_rdy} !== 4'b0000) begin
        errors++; $display("FAIL stray_rdy%0d: en/busy/rdy=%b want 0000", k, {mem_en, busy, req_rdy});
      end
    end
    mem_rdy = 1'b0;
  endtask

  task automatic test_drop_en();
    req_en = 2'b10; req_addr[63:32] = 32'h400;
    step();
    checks++;
    if (grant !== 3'd1 || mem_addr !== 32'h400) begin
      errors++; $display("FAIL drop_issue: grant=%0d addr=%h want 1 400", grant, mem_addr);
    end
    req_en = 2'b00;
    step();
    checks++;
    if (mem_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_hold: en=%b busy=%b want 1 1", mem_en, busy);
    end
    mem_rdy = 1'b1;
    step();
    checks++;
    if (req_rdy !== 2'b10) begin
      errors++; $display("FAIL drop_resp: rdy=%b want 10", req_rdy);
    end
    mem_rdy = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4];
    int n;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_en = 2'b11; req_wr = 2'b00; req_addr = {32'h20, 32'h10}; mem_rdy = 1'b1; mem_rdata = 32'h55;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (req_rdy !== 2'b00) begin
        checks++;
        if (req_rdy !== exp_rdy[n] || grant !== ((exp_rdy[n] == 2'b10) ? 3'd1 : 3'd0)) begin
          errors++; $display("FAIL contention%0d: rdy=%b grant=%0d want %b", n, req_rdy, grant, exp_rdy[n]);
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL contention_timeout: got %0d completions want 4", n);
    end
    req_en = 2'b00; mem_rdy = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_busy();
    req_en = 2'b10;
    step();
    checks++;
    if (mem_en !== 1'b1 || grant !== 3'd1) begin
      errors++; $display("FAIL midrst_issue: en=%b grant=%0d want 1 1", mem_en, grant);
    end
    reset = 1'b1; mem_rdy = 1'b1;
    step();
    checks++;
    if ({mem_en, busy, req_rdy} !== 4'b0000 || grant !== 3'd0) begin
      errors++; $display("FAIL midrst_state: en/busy/rdy=%b grant=%0d want 0000 0", {mem_en, busy, req_rdy}, grant);
    end
    reset = 1'b0; mem_rdy = 1'b0; req_en = 2'b00;
    step();
    checks++;
    if (req_rdy !== 2'b00) begin
      errors++; $display("FAIL midrst_late_rdy: rdy=%b want 00", req_rdy);
    end
    req_en = 2'b11;
    step();
    checks++;
    if (grant !== 3'd0 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL midrst_first: grant=%0d addr=%h want 0 10", grant, mem_addr);
    end
    mem_rdy = 1'b1;
    step();
    checks++;
    if (req_rdy !== 2'b01) begin
      errors++; $display("FAIL midrst_resp: rdy=%b want 01", req_rdy);
    end
    mem_rdy = 1'b0; req_en = 2'b00;
    step();
  endtask

  task automatic test_nports4();
    logic [3:0]  exp_rdy [3];
    logic [31:0] exp_addr [3];
    int n;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_rdy  = '{4'b0010, 4'b0010, 4'b0010};
    exp_addr = '{32'h1000, 32'h1000, 32'h1000};
`else
    exp_rdy  = '{4'b0010, 4'b1000, 4'b0010};
    exp_addr = '{32'h1000, 32'h3000, 32'h1000};
`endif
    q_req_en = 4'b1010; q_req_wr = 4'b0000;
    q_req_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    q_mem_rdy = 1'b1; q_mem_rdata = 32'h4444;
    n = 0;
    for (int c = 0; c < 15 && n < 3; c++) begin
      step();
      if (q_req_rdy !== 4'b0000) begin
        checks++;
        if (q_req_rdy !== exp_rdy[n] || q_mem_addr !== exp_addr[n] || q_req_rdata !== 32'h4444) begin
          errors++; $display("FAIL rr4_%0d: rdy=%b addr=%h rdata=%h want %b %h 4444",
                             n, q_req_rdy, q_mem_addr, q_req_rdata, exp_rdy[n], exp_addr[n]);
        end
        n++;
      end
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL rr4_timeout: got %0d completions want 3", n);
    end
    q_req_en = 4'b0000; q_mem_rdy = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_wait_states();
    test_drop_en();
    test_contention();
    test_reset_mid_busy();
    test_nports4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
